// File: rtl/stack_based_alu.sv
// stack_based_alu: LIFO operand stack with an integrated signed ALU.
// Each rising edge executes one opcode: NOP, PUSH, POP, ADD or MUL.
// ADD and MUL replace the top two entries with their result and report
// signed overflow. Opcodes that cannot complete (push when full, pop when
// empty, arithmetic with fewer than two entries) are ignored.
module stack_based_alu #(
   parameter int N     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] input_data,
   input  logic [2:0]   opcode,
   output logic [N-1:0] output_data,
   output logic         overflow
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(DEPTH);

   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   logic [1:0]       r_rstSync;
   logic [SPW-1:0]   r_sp;
   logic [N-1:0]     r_stack [DEPTH];
   logic [N-1:0]     r_outData;
   logic             r_overflow;

   logic             w_opEnable;
   logic [AW-1:0]    w_idxPush;
   logic [AW-1:0]    w_idxA;
   logic [AW-1:0]    w_idxB;
   logic [N-1:0]     w_a;
   logic [N-1:0]     w_b;
   logic [N-1:0]     w_sum;
   logic             w_sumOvf;
   logic [2*N-1:0]   w_prod;
   logic [N:0]       w_prodHi;
   logic             w_prodOvf;
   logic             w_hasOne;
   logic             w_hasTwo;
   logic             w_notFull;
   logic             w_doPush;
   logic             w_doPop;
   logic             w_doAdd;
   logic             w_doMul;

   // Reset release is re-timed to the clock so no op runs on a partial edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end

   assign w_opEnable = r_rstSync[1];

   // Occupancy tests; sp counts entries, so the top lives at sp-1
   assign w_hasOne  = (r_sp != '0);
   assign w_hasTwo  = (r_sp >= SPW'(2));
   assign w_notFull = (r_sp != SPW'(DEPTH));

   assign w_idxPush = r_sp[AW-1:0];
   assign w_idxB    = r_sp[AW-1:0] - AW'(1);
   assign w_idxA    = r_sp[AW-1:0] - AW'(2);

   assign w_a = r_stack[w_idxA];
   assign w_b = r_stack[w_idxB];

   // Two's complement sum; overflow when like-signed operands flip sign
   assign w_sum    = w_a + w_b;
   assign w_sumOvf = (w_a[N-1] == w_b[N-1]) && (w_sum[N-1] != w_a[N-1]);

   // Sign-extended operands give the exact signed product in 2N bits;
   // it fits in N bits only if the top N+1 bits are all equal
   assign w_prod    = {{N{w_a[N-1]}}, w_a} * {{N{w_b[N-1]}}, w_b};
   assign w_prodHi  = w_prod[2*N-1:N-1];
   assign w_prodOvf = !((&w_prodHi) || (~|w_prodHi));

   assign w_doPush = w_opEnable && (opcode == OP_PUSH) && w_notFull;
   assign w_doPop  = w_opEnable && (opcode == OP_POP)  && w_hasOne;
   assign w_doAdd  = w_opEnable && (opcode == OP_ADD)  && w_hasTwo;
   assign w_doMul  = w_opEnable && (opcode == OP_MUL)  && w_hasTwo;

   // Stack pointer and registered outputs; ignored ops fall through and hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp       <= '0;
         r_outData  <= '0;
         r_overflow <= 1'b0;
      end else if (w_doPush) begin
         r_sp <= r_sp + SPW'(1);
      end else if (w_doPop) begin
         r_outData <= w_b;
         r_sp      <= r_sp - SPW'(1);
      end else if (w_doAdd) begin
         r_outData  <= w_sum;
         r_overflow <= w_sumOvf;
         r_sp       <= r_sp - SPW'(1);
      end else if (w_doMul) begin
         r_outData  <= w_prod[N-1:0];
         r_overflow <= w_prodOvf;
         r_sp       <= r_sp - SPW'(1);
      end
   end

   // Stack storage is not reset; only slots below sp are ever read
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_stack[w_idxPush] <= input_data;
      end else if (w_doAdd) begin
         r_stack[w_idxA] <= w_sum;
      end else if (w_doMul) begin
         r_stack[w_idxA] <= w_prod[N-1:0];
      end
   end

   assign output_data = r_outData;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_stack_based_alu.sv
// tb_stack_based_alu: directed scenarios with hand-computed expectations.
module tb_stack_based_alu;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] ADD  = 3'b100;
   localparam logic [2:0] MUL  = 3'b101;
   localparam logic [2:0] PUSH = 3'b110;
   localparam logic [2:0] POP  = 3'b111;

   logic        clk;
   logic        rst_n;
   logic [31:0] input_data;
   logic [2:0]  opcode;
   logic [31:0] output_data;
   logic        overflow;

   int nCompared;
   int nMismatched;

   stack_based_alu #(.N(32), .DEPTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_data  (input_data),
      .opcode      (opcode),
      .output_data (output_data),
      .overflow    (overflow)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one opcode for one edge, then return 1 time unit after it
   task automatic doOp(input logic [2:0] op, input logic [31:0] d);
      opcode     = op;
      input_data = d;
      @(posedge clk);
      #1;
      opcode     = NOP;
      input_data = '0;
   endtask

   // Release reset away from an edge and let the internal sync settle
   task automatic releaseReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      opcode     = NOP;
      input_data = '0;
      #2;
      nCompared++;
      if (output_data !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_out: got %h want %h", output_data, 32'h0);
      end
      nCompared++;
      if (overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ovf: got %b want %b", overflow, 1'b0);
      end
      releaseReset();
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_pop_empty: got %h want %h", output_data, 32'h0);
      end
   endtask

   task automatic test_add_basic();
      doOp(PUSH, 3);
      doOp(PUSH, 4);
      doOp(ADD, 0);
      nCompared++;
      if (output_data !== 32'd7 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL add_basic: got %h/%b want %h/%b", output_data, overflow, 32'd7, 1'b0);
      end
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd7) begin
         nMismatched++;
         $display("[TB] FAIL add_basic_pop: got %h want %h", output_data, 32'd7);
      end
      doOp(PUSH, 9);
      doOp(POP, 0);
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd9) begin
         nMismatched++;
         $display("[TB] FAIL add_basic_single_entry: got %h want %h", output_data, 32'd9);
      end
   endtask

   task automatic test_postfix();
      doOp(PUSH, 2);
      doOp(PUSH, 3);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'd6 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL postfix_mul: got %h/%b want %h/%b", output_data, overflow, 32'd6, 1'b0);
      end
      doOp(PUSH, 4);
      doOp(ADD, 0);
      nCompared++;
      if (output_data !== 32'd10 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL postfix_add: got %h/%b want %h/%b", output_data, overflow, 32'd10, 1'b0);
      end
      doOp(POP, 0);
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd10) begin
         nMismatched++;
         $display("[TB] FAIL postfix_empty_pop: got %h want %h", output_data, 32'd10);
      end
   endtask

   task automatic test_add_overflow();
      doOp(PUSH, 32'h7FFF_FFFF);
      doOp(PUSH, 32'h1);
      doOp(ADD, 0);
      nCompared++;
      if (output_data !== 32'h8000_0000 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL add_ovf: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0000, 1'b1);
      end
      doOp(PUSH, 32'h1);
      nCompared++;
      if (output_data !== 32'h8000_0000 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL add_ovf_push_hold: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0000, 1'b1);
      end
      doOp(ADD, 0);
      nCompared++;
      if (output_data !== 32'h8000_0001 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL add_ovf_clear: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0001, 1'b0);
      end
      doOp(POP, 0);
   endtask

   task automatic test_mul_overflow();
      doOp(PUSH, 32'h0001_0000);
      doOp(PUSH, 32'h0001_0000);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'h0 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL mul_ovf: got %h/%b want %h/%b", output_data, overflow, 32'h0, 1'b1);
      end
      doOp(POP, 0);
      doOp(PUSH, 32'hFFFF_FFFD);
      doOp(PUSH, 32'd5);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'hFFFF_FFF1 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL mul_neg: got %h/%b want %h/%b", output_data, overflow, 32'hFFFF_FFF1, 1'b0);
      end
      doOp(POP, 0);
      doOp(PUSH, 32'h8000_0000);
      doOp(PUSH, 32'hFFFF_FFFF);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'h8000_0000 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL mul_minint: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0000, 1'b1);
      end
      doOp(POP, 0);
      doOp(PUSH, 32'hFFFF_FFFF);
      doOp(PUSH, 32'hFFFF_FFFF);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'h1 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL mul_negneg: got %h/%b want %h/%b", output_data, overflow, 32'h1, 1'b0);
      end
      doOp(POP, 0);
   endtask

   task automatic test_boundaries();
      doOp(PUSH, 32'h7FFF_FFFF);
      doOp(PUSH, 32'h1);
      doOp(ADD, 0);
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'h8000_0000 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL pop_holds_ovf: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0000, 1'b1);
      end
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'h8000_0000) begin
         nMismatched++;
         $display("[TB] FAIL pop_empty: got %h want %h", output_data, 32'h8000_0000);
      end
      doOp(PUSH, 32'd6);
      doOp(ADD, 0);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'h8000_0000 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL arith_one_entry: got %h/%b want %h/%b", output_data, overflow, 32'h8000_0000, 1'b1);
      end
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd6) begin
         nMismatched++;
         $display("[TB] FAIL arith_one_entry_pop: got %h want %h", output_data, 32'd6);
      end
      for (int i = 1; i <= 9; i++) begin
         doOp(PUSH, 32'(i));
      end
      for (int i = 8; i >= 1; i--) begin
         doOp(POP, 0);
         nCompared++;
         if (output_data !== 32'(i)) begin
            nMismatched++;
            $display("[TB] FAIL full_pop_%0d: got %h want %h", i, output_data, 32'(i));
         end
      end
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd1) begin
         nMismatched++;
         $display("[TB] FAIL full_drained: got %h want %h", output_data, 32'd1);
      end
   endtask

   task automatic test_reset_midseq();
      doOp(PUSH, 32'h7FFF_FFFF);
      doOp(PUSH, 32'h1);
      doOp(ADD, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (output_data !== 32'h0 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midseq_reset: got %h/%b want %h/%b", output_data, overflow, 32'h0, 1'b0);
      end
      releaseReset();
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL midseq_pop_empty: got %h want %h", output_data, 32'h0);
      end
      doOp(PUSH, 32'd4);
      doOp(POP, 0);
      nCompared++;
      if (output_data !== 32'd4) begin
         nMismatched++;
         $display("[TB] FAIL midseq_resume: got %h want %h", output_data, 32'd4);
      end
   endtask

   task automatic test_back_to_back();
      doOp(PUSH, 32'd10);
      doOp(PUSH, 32'hFFFF_FFFE);
      doOp(PUSH, 32'd3);
      doOp(MUL, 0);
      nCompared++;
      if (output_data !== 32'hFFFF_FFFA) begin
         nMismatched++;
         $display("[TB] FAIL b2b_mul: got %h want %h", output_data, 32'hFFFF_FFFA);
      end
      doOp(ADD, 0);
      nCompared++;
      if (output_data !== 32'd4 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_add: got %h/%b want %h/%b", output_data, overflow, 32'd4, 1'b0);
      end
      doOp(POP, 0);
   endtask

   // Scenario sequence and summary
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_add_basic();
      test_postfix();
      test_add_overflow();
      test_mul_overflow();
      test_boundaries();
      test_back_to_back();
      test_reset_midseq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/stack_based_alu.md
Name: stack_based_alu

Overview:
- Synchronous LIFO operand stack with an integrated signed ALU, parameterised in data width.
- Each clock cycle executes one opcode: push an operand, pop the top, or replace the top two entries with their sum or product.
- Serves as the arithmetic engine of the postfix-expression evaluator. The evaluator presents an opcode with its operand and reads back results and the overflow flag.

Parameters:
- N, 32, data width in bits of operands, stack entries and result.
- DEPTH, 8, number of stack entries; must be 2 or more.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- input_data  input  N  signed operand for PUSH.
- opcode  input  3  operation select, sampled every rising edge.
- output_data  output  N  registered result of the last POP, ADD or MUL.
- overflow  output  1  registered signed-overflow flag of the last ADD or MUL.

Behaviour:
- Reset (rst_n low, asynchronous):
  - stack pointer = 0 (stack empty), output_data = 0, overflow = 0.
  - Stack contents are don't-care.
  - Deassertion is synchronised internally so the first operation happens on a clean edge.
- Opcode map:
  - 0xx: NOP.
  - 100: ADD.
  - 101: MUL.
  - 110: PUSH.
  - 111: POP.
- Every operation takes one cycle. Results are visible on output_data and overflow after the executing edge, with no handshake.
- NOP: all state held.
- PUSH:
  - If count < DEPTH, write input_data to stack[sp] and increment sp.
  - output_data and overflow are held.
  - If full (count == DEPTH), ignored: no write, all state held.
- POP:
  - If count ≥ 1, output_data = stack[sp-1] and decrement sp.
  - overflow is held.
  - If empty, ignored: output_data and sp held.
- ADD (requires count ≥ 2):
  - Let A = stack[sp-2] and B = stack[sp-1], both two's complement.
  - S = A + B truncated to N bits.
  - stack[sp-2] = S, output_data = S, sp decrements by 1.
  - overflow = 1 when A and B have equal sign bits and S's sign differs; else 0.
- MUL (requires count ≥ 2):
  - P = full 2N-bit signed product A × B.
  - Result = P[N-1:0], written to stack[sp-2] and output_data; sp decrements by 1.
  - overflow = 1 unless P[2N-1:N-1] is all zeros or all ones (the product does not fit in N signed bits); else 0.
- ADD or MUL with count < 2: ignored. Stack, sp and output_data are held, and overflow is held.
- overflow is not sticky: each executed ADD or MUL rewrites it. PUSH, POP, NOP and ignored ops keep it.
- Stack pointer range is 0..DEPTH and never wraps.
- Reset asserted mid-sequence empties the stack immediately, regardless of clk.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then PUSH 3, PUSH 4, ADD -> output_data = 7, overflow = 0, count = 1; then POP -> output_data = 7, stack empty.
- PUSH 2, PUSH 3, MUL, PUSH 4, ADD (postfix "23*4+") -> output_data = 10 after ADD, overflow = 0.
- PUSH 0x7FFFFFFF, PUSH 1, ADD -> output_data = 0x80000000, overflow = 1; next PUSH 1, ADD -> output_data = 0x80000001, overflow = 0.
- PUSH 0x00010000 twice, MUL -> output_data = 0, overflow = 1; PUSH -3, PUSH 5, MUL -> output_data = 0xFFFFFFF1 (−15), overflow = 0.
- Boundaries:
  - POP when empty -> output_data unchanged.
  - ADD with one entry -> no change.
  - DEPTH+1 PUSHes of 1..9 -> ninth ignored; eight POPs return 8,7,...,1.
- Assert rst_n low mid-sequence between clock edges -> outputs go to 0 immediately; a subsequent POP is ignored (empty).
